// File: rtl/writeback_unit.sv
// Final pipeline stage: accepts one retiring instruction per handshake, waits for
// load data when needed, extends/aligns it and drives a one-cycle register-file write.
module writeback_unit #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic                  in_wen,
    input  logic                  in_is_load,
    input  logic [2:0]            in_funct3,
    input  logic [DATA_WIDTH-1:0] in_result,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  rf_valid,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] busy_rd
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        COMMIT   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] rd_q, rd_d;
    logic                  wen_q, wen_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [1:0]            addr_q, addr_d;
    logic                  rf_valid_q, rf_valid_d;
    logic                  rf_wen_q, rf_wen_d;
    logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
    logic                  busy_q, busy_d;
    logic [ADDR_WIDTH-1:0] busy_rd_q, busy_rd_d;

    logic                  accept;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [DATA_WIDTH-1:0] ld_data;

    always_comb begin
        in_ready = (state_q != WAIT_MEM) & ~reset;
        accept   = in_valid & in_ready;
    end

    // Load lane select and extension from the latched funct3 / address bits.
    always_comb begin
        ld_byte = '0;
        case (addr_q)
            2'd0: ld_byte = mem_rdata[7:0];
            2'd1: ld_byte = mem_rdata[15:8];
            2'd2: ld_byte = mem_rdata[23:16];
            2'd3: ld_byte = mem_rdata[31:24];
            default: ld_byte = mem_rdata[7:0];
        endcase
        ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  ld_data = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
            3'b100:  ld_data = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
            3'b101:  ld_data = {{(DATA_WIDTH-16){1'b0}}, ld_half};
            default: ld_data = mem_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        rd_d       = rd_q;
        wen_d      = wen_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        busy_rd_d  = busy_rd_q;
        rf_valid_d = 1'b0;
        rf_wen_d   = 1'b0;
        rf_waddr_d = '0;
        rf_wdata_d = '0;

        case (state_q)
            WAIT_MEM: begin
                if (mem_rvalid) begin
                    state_d    = COMMIT;
                    rf_valid_d = 1'b1;
                    rf_wen_d   = wen_q & (rd_q != '0);
                    rf_waddr_d = rd_q;
                    rf_wdata_d = ld_data;
                end
            end
            default: begin
                // IDLE and COMMIT share the accept path, giving back-to-back retirement.
                if (accept) begin
                    rd_d      = in_rd;
                    wen_d     = in_wen;
                    funct3_d  = in_funct3;
                    addr_d    = in_result[1:0];
                    busy_rd_d = in_wen ? in_rd : '0;
                    if (in_is_load) begin
                        state_d = WAIT_MEM;
                    end else begin
                        state_d    = COMMIT;
                        rf_valid_d = 1'b1;
                        rf_wen_d   = in_wen & (in_rd != '0);
                        rf_waddr_d = in_rd;
                        rf_wdata_d = in_result;
                    end
                end else begin
                    state_d   = IDLE;
                    busy_rd_d = '0;
                end
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rd_q       <= '0;
            wen_q      <= 1'b0;
            funct3_q   <= '0;
            addr_q     <= '0;
            rf_valid_q <= 1'b0;
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            busy_q     <= 1'b0;
            busy_rd_q  <= '0;
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            wen_q      <= wen_d;
            funct3_q   <= funct3_d;
            addr_q     <= addr_d;
            rf_valid_q <= rf_valid_d;
            rf_wen_q   <= rf_wen_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            busy_q     <= busy_d;
            busy_rd_q  <= busy_rd_d;
        end
    end

    always_comb begin
        rf_valid = rf_valid_q;
        rf_wen   = rf_wen_q;
        rf_waddr = rf_waddr_q;
        rf_wdata = rf_wdata_q;
        busy     = busy_q;
        busy_rd  = busy_rd_q;
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: stimulus pushes expected retirements,
// a negedge monitor pops and compares on every rf_valid pulse.
module tb_writeback_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_rd;
    logic        in_wen;
    logic        in_is_load;
    logic [2:0]  in_funct3;
    logic [31:0] in_result;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rf_valid;
    logic        rf_wen;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        busy;
    logic [3:0]  busy_rd;

    typedef struct {
        logic        wen;
        logic [3:0]  waddr;
        logic [31:0] wdata;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    writeback_unit #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rd      (in_rd),
        .in_wen     (in_wen),
        .in_is_load (in_is_load),
        .in_funct3  (in_funct3),
        .in_result  (in_result),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .rf_valid   (rf_valid),
        .rf_wen     (rf_wen),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .busy       (busy),
        .busy_rd    (busy_rd)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (rf_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("stray_rf_valid", {31'd0, rf_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("rf_wen",   {31'd0, rf_wen},   {31'd0, e.wen});
                check("rf_waddr", {28'd0, rf_waddr}, {28'd0, e.waddr});
                check("rf_wdata", rf_wdata,          e.wdata);
            end
        end else if (rf_wen !== 1'b0) begin
            check("rf_wen_outside_commit", {31'd0, rf_wen}, 32'd0);
        end
    end

    task automatic alu(input logic [3:0] rd, input logic wen, input logic [31:0] res);
        check("alu_busy_before", {31'd0, busy}, 32'd0);
        in_valid = 1'b1; in_is_load = 1'b0; in_rd = rd; in_wen = wen;
        in_funct3 = 3'b000; in_result = res;
        exp_q.push_back('{wen && (rd != 4'd0), rd, res});
        @(posedge clock); #1;
        in_valid = 1'b0;
        check("alu_busy",    {31'd0, busy},    32'd1);
        check("alu_busy_rd", {28'd0, busy_rd}, wen ? {28'd0, rd} : 32'd0);
        @(posedge clock); #1;
        check("alu_busy_clear", {31'd0, busy}, 32'd0);
    endtask

    // Data arrives "lat" cycles after the accept edge; a stale mem_rvalid is
    // driven during the accept cycle and must be ignored.
    task automatic load(input logic [3:0] rd, input logic wen, input logic [2:0] f3,
                        input logic [31:0] addr, input int unsigned lat,
                        input logic [31:0] rdata, input logic [31:0] expv);
        in_valid = 1'b1; in_is_load = 1'b1; in_rd = rd; in_wen = wen;
        in_funct3 = f3; in_result = addr;
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        exp_q.push_back('{wen && (rd != 4'd0), rd, expv});
        @(posedge clock); #1;
        in_valid = 1'b0; in_is_load = 1'b0; mem_rvalid = 1'b0;
        check("load_busy",    {31'd0, busy},    32'd1);
        check("load_busy_rd", {28'd0, busy_rd}, wen ? {28'd0, rd} : 32'd0);
        for (int unsigned i = 1; i < lat; i++) begin
            check("load_in_ready_wait", {31'd0, in_ready}, 32'd0);
            @(posedge clock); #1;
        end
        check("load_in_ready_wait", {31'd0, in_ready}, 32'd0);
        mem_rvalid = 1'b1; mem_rdata = rdata;
        @(posedge clock); #1;
        mem_rvalid = 1'b0; mem_rdata = 32'h5A5A_5A5A;
        check("load_commit_valid", {31'd0, rf_valid}, 32'd1);
        @(posedge clock); #1;
        check("load_busy_clear", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_rd = '0; in_wen = 1'b0; in_is_load = 1'b0;
        in_funct3 = '0; in_result = '0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_rf_valid", {31'd0, rf_valid}, 32'd0);
        check("rst_rf_wen",   {31'd0, rf_wen},   32'd0);
        check("rst_rf_wdata", rf_wdata,          32'd0);
        check("rst_busy",     {31'd0, busy},     32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        alu(4'd5, 1'b1, 32'h1234_5678);

        load(4'd7,  1'b1, 3'b000, 32'h0000_1003, 3, 32'h80AA_BBCC, 32'hFFFF_FF80);
        load(4'd8,  1'b1, 3'b100, 32'h0000_2001, 1, 32'h80AA_BBCC, 32'h0000_00BB);
        load(4'd9,  1'b1, 3'b101, 32'h0000_2002, 2, 32'h80AA_BBCC, 32'h0000_80AA);
        load(4'd10, 1'b1, 3'b001, 32'h0000_2000, 1, 32'h80AA_BBCC, 32'hFFFF_BBCC);
        load(4'd11, 1'b1, 3'b010, 32'h0000_2003, 2, 32'h80AA_BBCC, 32'h80AA_BBCC);
        load(4'd12, 1'b1, 3'b000, 32'h0000_2000, 1, 32'h80AA_BBCC, 32'hFFFF_FFCC);
        load(4'd13, 1'b1, 3'b100, 32'h0000_2002, 1, 32'h80AA_BBCC, 32'h0000_00AA);
        load(4'd14, 1'b1, 3'b001, 32'h0000_2003, 1, 32'h80AA_BBCC, 32'hFFFF_80AA);
        load(4'd15, 1'b1, 3'b011, 32'h0000_2001, 1, 32'h80AA_BBCC, 32'h80AA_BBCC);
        load(4'd1,  1'b1, 3'b000, 32'h0000_2000, 4, 32'h1234_567F, 32'h0000_007F);
        load(4'd2,  1'b1, 3'b101, 32'h0000_2000, 1, 32'h1234_7FFF, 32'h0000_7FFF);
        load(4'd3,  1'b0, 3'b010, 32'h0000_2000, 1, 32'hCAFE_F00D, 32'hCAFE_F00D);

        // Back-to-back ALU ops with in_valid held high.
        in_valid = 1'b1; in_is_load = 1'b0; in_wen = 1'b1; in_funct3 = 3'b000;
        for (int unsigned i = 1; i <= 4; i++) begin
            in_rd = 4'(i);
            in_result = 32'hA000_0000 + 32'(i);
            exp_q.push_back('{1'b1, 4'(i), 32'hA000_0000 + 32'(i)});
            check("b2b_in_ready", {31'd0, in_ready}, 32'd1);
            @(posedge clock); #1;
            check("b2b_rf_valid", {31'd0, rf_valid}, 32'd1);
            check("b2b_busy_rd",  {28'd0, busy_rd},  i);
        end
        in_valid = 1'b0;
        @(posedge clock); #1;
        check("b2b_busy_clear", {31'd0, busy}, 32'd0);

        alu(4'd0, 1'b1, 32'hFFFF_0001);
        alu(4'd6, 1'b0, 32'h0000_0042);

        // Reset while waiting for load data: the load must vanish.
        in_valid = 1'b1; in_is_load = 1'b1; in_rd = 4'd9; in_wen = 1'b1;
        in_funct3 = 3'b010; in_result = 32'h0000_3000;
        @(posedge clock); #1;
        in_valid = 1'b0; in_is_load = 1'b0;
        check("rst_mid_busy_before", {31'd0, busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_busy",     {31'd0, busy},     32'd0);
        check("rst_mid_busy_rd",  {28'd0, busy_rd},  32'd0);
        check("rst_mid_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
        @(posedge clock); #1;
        mem_rvalid = 1'b0;
        check("rst_mid_no_retire", {31'd0, rf_valid}, 32'd0);
        check("rst_mid_idle_busy", {31'd0, busy},     32'd0);
        check("rst_mid_in_ready",  {31'd0, in_ready}, 32'd1);

        alu(4'd4, 1'b1, 32'h0BAD_CAFE);

        repeat (3) @(posedge clock);
        #1;
        check("pending_retires", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
